fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_redir_buf.sv | 30 +++
 rtl/fetch_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state enum, word width and default reset PC for the fetch controller.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} fetch_state_e;
endpackage

// File: rtl/fetch_redir_buf.sv
// fetch_redir_buf: pending redirect target plus drop flag for the fetch still in flight.
module fetch_redir_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set,
  input  logic            clr,
  input  logic [XLEN-1:0] tgt,
  output logic            drop,
  output logic [XLEN-1:0] pend
);
  logic            drop_d, drop_q;
  logic [XLEN-1:0] pend_d, pend_q;
  always_comb begin
    drop_d = set ? 1'b1 : clr ? 1'b0 : drop_q;
    pend_d = set ? tgt : pend_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
      pend_q <= '0;
    end else begin
      drop_q <= drop_d;
      pend_q <= pend_d;
    end
  end
  assign drop = drop_q;
  assign pend = pend_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with redirect handling.
// Define FETCH_CTRL_ALIGN_CHK_EN to reject misaligned redirects and flag misalign_err.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            misalign_err
);
  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q, inst_d, inst_q, inst_pc_d, inst_pc_q;
  logic [XLEN-1:0] tgt, pend, pend_now;
  logic            redir_ok, drop, drop_now, set, clr;
`ifdef FETCH_CTRL_ALIGN_CHK_EN
  logic misalign_d, misalign_q;
  assign redir_ok   = redir_valid && (redir_pc[1:0] == 2'b00);
  assign tgt        = redir_pc;
  assign misalign_d = redir_valid && (redir_pc[1:0] != 2'b00);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else misalign_q <= misalign_d;
  end
  assign misalign_err = misalign_q;
`else
  assign redir_ok     = redir_valid;
  assign tgt          = redir_pc & ~XLEN'(3);
  assign misalign_err = 1'b0;
`endif
  fetch_redir_buf u_redir_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .set  (set),
    .clr  (clr),
    .tgt  (tgt),
    .drop (drop),
    .pend (pend)
  );
  // a redirect landing with the response drops it just like an earlier one
  assign drop_now = drop || redir_ok;
  assign pend_now = redir_ok ? tgt : pend;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    set       = 1'b0;
    clr       = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d    = redir_ok ? tgt : pc_q;
        state_d = stall ? IDLE : REQ;
      end
      REQ: begin
        set     = redir_ok;
        state_d = imem_req_ready ? WAIT : REQ;
      end
      WAIT: begin
        set = redir_ok && !imem_rsp_valid;
        if (imem_rsp_valid) begin
          clr       = 1'b1;
          state_d   = drop_now ? REQ : VALID;
          pc_d      = drop_now ? pend_now : pc_q + XLEN'(4);
          inst_d    = drop_now ? inst_q : imem_rsp_data;
          inst_pc_d = drop_now ? inst_pc_q : pc_q;
        end
      end
      VALID: begin
        pc_d    = redir_ok ? tgt : pc_q;
        state_d = (redir_ok || (inst_ready && !stall)) ? REQ : VALID;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end
  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == VALID);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc_plus4       = inst_pc_q + XLEN'(4);
endmodule
